// File: rtl/uart_io_arbiter_if.sv
// AXI4-Lite bus between the I/O arbiter (master) and the UART-Lite peripheral (slave).
interface uart_io_arbiter_if;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/uart_io_arbiter.sv
// Sequences core IN/OUT byte requests onto one AXI4-Lite master port to a UART-Lite.
// Every data access is preceded by a STAT poll; failed polls back off for POLL_GAP cycles.
// Optional macro UART_IO_TIMEOUT_EN: per-transaction cycle limit (TIMEOUT) that aborts
// a transaction stuck polling, completing it with ACK and setting ERR.
module uart_io_arbiter #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_REQ,
  output logic [7:0] IN_DATA,
  output logic       IN_ACK,
  input  logic       OUT_REQ,
  input  logic [7:0] OUT_DATA,
  output logic       OUT_ACK,
  output logic       ERR,
  uart_io_arbiter_if.master axi
);

  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;

  localparam int unsigned GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned GAP_LAST = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;

  typedef enum logic [3:0] {
    IDLE, POLL_AR, POLL_R, GAP, RX_AR, RX_R, TX_W, TX_B, DONE
  } state_t;

  state_t           state, state_nx;
  logic             grant_out;    // 1: current transaction is OUT
  logic             last_out;     // 1: last grant went to OUT
  logic             grant_out_nx;
  logic [7:0]       tx_byte;
  logic [7:0]       in_data_q;
  logic             err_q;
  logic             aw_done, w_done;
  logic [GAP_W-1:0] gap_cnt;
  logic             timed_out;
  logic             abort;
  logic             poll_ok;

  logic [3:0]       ar_addr;
  logic             ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic             r_hs, b_hs, aw_hs, w_hs;

  logic [23:0]      unused_rdata;
  assign unused_rdata = axi.RDATA[31:8];

  // Tie-break on simultaneous requests alternates, starting with IN after reset.
  assign grant_out_nx = OUT_REQ && (!IN_REQ || !last_out);
  assign poll_ok      = grant_out ? !axi.RDATA[3] : axi.RDATA[0];

  assign r_hs  = axi.RVALID  && r_ready;
  assign b_hs  = axi.BVALID  && b_ready;
  assign aw_hs = aw_valid    && axi.AWREADY;
  assign w_hs  = w_valid     && axi.WREADY;

`ifdef UART_IO_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Transaction age; held at zero in IDLE so it restarts at every grant, saturates at TIMEOUT.
  always_ff @(posedge CLK) begin
    if (RST)                to_cnt <= '0;
    else if (state == IDLE) to_cnt <= '0;
    else if (!timed_out)    to_cnt <= to_cnt + 32'd1;
  end

  assign timed_out = (to_cnt >= TIMEOUT);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and bus control decode.
  always_comb begin
    state_nx = state;
    ar_addr  = '0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (IN_REQ || OUT_REQ) state_nx = POLL_AR;
      end
      POLL_AR: begin
        ar_addr  = ADDR_STAT;
        ar_valid = 1'b1;
        // A handshake completing this cycle wins over an abort.
        if (axi.ARREADY) begin
          state_nx = POLL_R;
        end else if (timed_out) begin
          state_nx = DONE;
          abort    = 1'b1;
        end
      end
      POLL_R: begin
        r_ready = 1'b1;
        if (axi.RVALID) begin
          if (poll_ok)            state_nx = grant_out ? TX_W : RX_AR;
          else if (POLL_GAP == 0) state_nx = POLL_AR;
          else                    state_nx = GAP;
        end
      end
      GAP: begin
        if (timed_out) begin
          state_nx = DONE;
          abort    = 1'b1;
        end else if (gap_cnt == GAP_W'(GAP_LAST)) begin
          state_nx = POLL_AR;
        end
      end
      RX_AR: begin
        ar_addr  = ADDR_RX;
        ar_valid = 1'b1;
        if (axi.ARREADY) state_nx = RX_R;
      end
      RX_R: begin
        r_ready = 1'b1;
        if (axi.RVALID) state_nx = DONE;
      end
      TX_W: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        if ((aw_done || axi.AWREADY) && (w_done || axi.WREADY)) state_nx = TX_B;
      end
      TX_B: begin
        b_ready = 1'b1;
        if (axi.BVALID) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant bookkeeping, write-phase progress, backoff counter, read data and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_out <= 1'b0;
      last_out  <= 1'b1;
      tx_byte   <= '0;
      in_data_q <= '0;
      err_q     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      if (state == IDLE && (IN_REQ || OUT_REQ)) begin
        grant_out <= grant_out_nx;
        last_out  <= grant_out_nx;
        if (grant_out_nx) tx_byte <= OUT_DATA;
      end

      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;

      if (state == TX_W) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      if (state == RX_R && axi.RVALID)  in_data_q <= axi.RDATA[7:0];
      else if (abort && !grant_out)     in_data_q <= '0;

      if ((r_hs && axi.RRESP != 2'b00) || (b_hs && axi.BRESP != 2'b00) || abort)
        err_q <= 1'b1;
    end
  end

  assign axi.ARADDR  = ar_addr;
  assign axi.ARVALID = ar_valid;
  assign axi.RREADY  = r_ready;
  assign axi.AWADDR  = (state == TX_W) ? ADDR_TX : 4'h0;
  assign axi.AWVALID = aw_valid;
  assign axi.WDATA   = (state == TX_W) ? {24'h0, tx_byte} : 32'h0;
  assign axi.WSTRB   = (state == TX_W) ? 4'b0001 : 4'b0000;
  assign axi.WVALID  = w_valid;
  assign axi.BREADY  = b_ready;

  assign IN_ACK  = (state == DONE) && !grant_out;
  assign OUT_ACK = (state == DONE) &&  grant_out;
  assign IN_DATA = in_data_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_uart_io_arbiter.sv
// Self-checking bench for uart_io_arbiter with a behavioural UART-Lite AXI slave.
module tb_uart_io_arbiter;

  localparam int unsigned GAP = 4;
  localparam int unsigned TO  = 64;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_REQ = 1'b0;
  logic       OUT_REQ = 1'b0;
  logic [7:0] OUT_DATA = 8'h00;
  logic [7:0] IN_DATA;
  logic       IN_ACK, OUT_ACK, ERR;

  uart_io_arbiter_if bus ();

  uart_io_arbiter #(.POLL_GAP(GAP), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .IN_REQ(IN_REQ), .IN_DATA(IN_DATA), .IN_ACK(IN_ACK),
    .OUT_REQ(OUT_REQ), .OUT_DATA(OUT_DATA), .OUT_ACK(OUT_ACK),
    .ERR(ERR), .axi(bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct { bit is_out; logic [7:0] data; } exp_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  exp_t       sb[$];
  wr_t        wr_log[$];
  logic [3:0] ar_log[$];
  int         ar_cyc[$];
  int         cyc = 0;

  // slave configuration
  logic [7:0] stat_q[$];
  logic [7:0] stat_default = 8'h01;
  logic [7:0] rx_byte = 8'h00;
  logic [1:0] rx_resp = 2'b00;
  int         aw_delay = 0;
  int         w_delay  = 0;
  bit         r_hold   = 1'b0;

  // slave state
  int          aw_age = 0, w_age = 0;
  bit          r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [3:0]  cap_aw = '0;
  logic [31:0] cap_wd = '0;
  logic [3:0]  cap_ws = '0;
  logic [7:0]  rd;
  bit          s_aw_hs, s_w_hs;
  wr_t         ent;

  int in_ack_cnt = 0, out_ack_cnt = 0;

  assign bus.ARREADY = 1'b1;
  assign bus.AWREADY = (aw_age >= aw_delay);
  assign bus.WREADY  = (w_age >= w_delay);

  always @(negedge CLK) begin
    if (IN_ACK)  in_ack_cnt++;
    if (OUT_ACK) out_ack_cnt++;
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      bus.RVALID <= 1'b0; bus.RDATA <= '0; bus.RRESP <= '0;
      bus.BVALID <= 1'b0; bus.BRESP <= '0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_age <= 0; w_age <= 0;
    end else begin
      if (bus.RVALID && bus.RREADY) bus.RVALID <= 1'b0;
      if (r_pend && !r_hold) begin bus.RVALID <= 1'b1; r_pend <= 1'b0; end
      if (bus.ARVALID && bus.ARREADY) begin
        ar_log.push_back(bus.ARADDR);
        ar_cyc.push_back(cyc);
        if (bus.ARADDR == 4'h8) begin
          if (stat_q.size() > 0) rd = stat_q.pop_front();
          else                   rd = stat_default;
          bus.RRESP <= 2'b00;
        end else begin
          rd = rx_byte;
          bus.RRESP <= rx_resp;
        end
        bus.RDATA <= {24'h0, rd};
        if (r_hold) r_pend <= 1'b1;
        else        bus.RVALID <= 1'b1;
      end
      s_aw_hs = bus.AWVALID && bus.AWREADY;
      s_w_hs  = bus.WVALID && bus.WREADY;
      if (bus.AWVALID && !bus.AWREADY) aw_age <= aw_age + 1; else aw_age <= 0;
      if (bus.WVALID && !bus.WREADY)   w_age  <= w_age + 1;  else w_age  <= 0;
      if (s_aw_hs) cap_aw <= bus.AWADDR;
      if (s_w_hs) begin cap_wd <= bus.WDATA; cap_ws <= bus.WSTRB; end
      if (bus.BVALID && bus.BREADY) bus.BVALID <= 1'b0;
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        ent.addr = s_aw_hs ? bus.AWADDR : cap_aw;
        ent.data = s_w_hs ? bus.WDATA : cap_wd;
        ent.strb = s_w_hs ? bus.WSTRB : cap_ws;
        wr_log.push_back(ent);
        bus.BVALID <= 1'b1;
        bus.BRESP  <= 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_got | s_aw_hs;
        w_got  <= w_got | s_w_hs;
      end
    end
  end

  task automatic wait_ack(input int limit, output int n, output bit expired);
    n = 0;
    expired = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      n++;
      if (IN_ACK || OUT_ACK) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY} !== 5'b0) begin
      bad++; $display("FAIL reset_valid_ready got=%b want=00000",
                      {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY});
    end
    total++;
    if ({IN_ACK, OUT_ACK, ERR} !== 3'b000) begin
      bad++; $display("FAIL reset_ack_err got=%b want=000", {IN_ACK, OUT_ACK, ERR});
    end
    total++;
    if ({bus.ARADDR, bus.AWADDR, bus.WSTRB} !== 12'h000) begin
      bad++; $display("FAIL reset_addr_strb got=%h want=000", {bus.ARADDR, bus.AWADDR, bus.WSTRB});
    end
    total++;
    if ({bus.WDATA, IN_DATA} !== 40'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {bus.WDATA, IN_DATA});
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_in_basic();
    int n; bit expired; exp_t e; logic [1:0] kind;
    stat_q = {8'h01}; rx_byte = 8'h5A; rx_resp = 2'b00;
    ar_log.delete();
    sb.push_back('{1'b0, 8'h5A});
    IN_REQ = 1'b1;
    wait_ack(50, n, expired);
    IN_REQ = 1'b0;
    total++;
    if (expired) begin bad++; $display("FAIL in_basic_ack_wait got=none want=ack"); end
    total++;
    if (n != 5) begin bad++; $display("FAIL in_basic_latency got=%0d want=5", n); end
    e = sb.pop_front();
    kind = e.is_out ? 2'b01 : 2'b10;
    total++;
    if ({IN_ACK, OUT_ACK} !== kind) begin
      bad++; $display("FAIL in_basic_kind got=%b want=%b", {IN_ACK, OUT_ACK}, kind);
    end
    total++;
    if (IN_DATA !== e.data) begin bad++; $display("FAIL in_basic_data got=%h want=%h", IN_DATA, e.data); end
    total++;
    if (ar_log.size() != 2 || ar_log[0] !== 4'h8 || ar_log[1] !== 4'h0) begin
      bad++; $display("FAIL in_basic_araddr got=size%0d want=8,0", ar_log.size());
    end
    total++;
    if (ERR !== 1'b0) begin bad++; $display("FAIL in_basic_err got=%b want=0", ERR); end
    @(negedge CLK);
    total++;
    if (IN_ACK !== 1'b0) begin bad++; $display("FAIL in_basic_pulse got=%b want=0", IN_ACK); end
  endtask

  task automatic test_out_poll();
    int n; bit expired; exp_t e; int base; int non_stat;
    stat_q = {8'h08, 8'h08, 8'h08, 8'h00};
    ar_log.delete(); ar_cyc.delete(); wr_log.delete();
    base = out_ack_cnt;
    OUT_DATA = 8'h41;
    sb.push_back('{1'b1, 8'h41});
    OUT_REQ = 1'b1;
    @(negedge CLK);
    // dropped after grant: transaction must still complete with the byte sampled at grant
    OUT_REQ = 1'b0;
    OUT_DATA = 8'hFF;
    wait_ack(200, n, expired);
    total++;
    if (expired) begin bad++; $display("FAIL out_poll_ack_wait got=none want=ack"); end
    e = sb.pop_front();
    total++;
    if ({IN_ACK, OUT_ACK} !== {!e.is_out, e.is_out}) begin
      bad++; $display("FAIL out_poll_kind got=%b want=01", {IN_ACK, OUT_ACK});
    end
    non_stat = 0;
    foreach (ar_log[i]) if (ar_log[i] !== 4'h8) non_stat++;
    total++;
    if (ar_log.size() != 4 || non_stat != 0) begin
      bad++; $display("FAIL out_poll_stat_reads got=%0d(non-stat %0d) want=4", ar_log.size(), non_stat);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (ar_cyc.size() <= i || ar_cyc[i] - ar_cyc[i-1] != int'(GAP) + 2) begin
        bad++; $display("FAIL out_poll_gap%0d got=%0d want=%0d", i,
                        (ar_cyc.size() > i) ? ar_cyc[i] - ar_cyc[i-1] : -1, GAP + 2);
      end
    end
    total++;
    if (wr_log.size() != 1 || wr_log[0].addr !== 4'h4 || wr_log[0].data !== {24'h0, e.data}
        || wr_log[0].strb !== 4'b0001) begin
      bad++; $display("FAIL out_poll_write got=n%0d a%h d%h s%b want=n1 a4 d%h s0001", wr_log.size(),
                      (wr_log.size() > 0) ? wr_log[0].addr : 4'hx,
                      (wr_log.size() > 0) ? wr_log[0].data : 32'hx,
                      (wr_log.size() > 0) ? wr_log[0].strb : 4'hx, {24'h0, e.data});
    end
    repeat (4) @(negedge CLK);
    total++;
    if (out_ack_cnt - base != 1) begin bad++; $display("FAIL out_poll_ack_count got=%0d want=1", out_ack_cnt - base); end
  endtask

  task automatic test_back_to_back();
    int n; bit expired; exp_t e; int base;
    stat_q.delete(); stat_default = 8'h01; rx_byte = 8'h33; OUT_DATA = 8'h77;
    wr_log.delete();
    base = in_ack_cnt + out_ack_cnt;
    sb.push_back('{1'b0, 8'h33}); sb.push_back('{1'b1, 8'h77});
    sb.push_back('{1'b0, 8'h33}); sb.push_back('{1'b1, 8'h77});
    IN_REQ = 1'b1; OUT_REQ = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ack(50, n, expired);
      if (t == 3) begin IN_REQ = 1'b0; OUT_REQ = 1'b0; end
      total++;
      if (expired || n != 5) begin bad++; $display("FAIL b2b_latency%0d got=%0d want=5", t, n); end
      e = sb.pop_front();
      total++;
      if ({IN_ACK, OUT_ACK} !== {!e.is_out, e.is_out}) begin
        bad++; $display("FAIL b2b_grant%0d got=%b want=%b", t, {IN_ACK, OUT_ACK}, {!e.is_out, e.is_out});
      end
      if (!e.is_out) begin
        total++;
        if (IN_DATA !== e.data) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", t, IN_DATA, e.data); end
      end
      @(negedge CLK);
      total++;
      if ({IN_ACK, OUT_ACK} !== 2'b00) begin bad++; $display("FAIL b2b_pulse%0d got=%b want=00", t, {IN_ACK, OUT_ACK}); end
    end
    repeat (10) @(negedge CLK);
    total++;
    if (in_ack_cnt + out_ack_cnt - base != 4) begin
      bad++; $display("FAIL b2b_ack_count got=%0d want=4", in_ack_cnt + out_ack_cnt - base);
    end
    total++;
    if (wr_log.size() != 2 || wr_log[1].data !== 32'h77) begin
      bad++; $display("FAIL b2b_writes got=%0d want=2 writes of 77", wr_log.size());
    end
  endtask

  task automatic test_split_handshake();
    int n; bit expired; exp_t e; bit found;
    aw_delay = 0; w_delay = 2;
    stat_q = {8'h00}; OUT_DATA = 8'h5C; wr_log.delete();
    sb.push_back('{1'b1, 8'h5C});
    OUT_REQ = 1'b1;
    @(negedge CLK);
    OUT_REQ = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.WVALID === 1'b1) begin found = 1'b1; break; end
      @(negedge CLK);
    end
    total++;
    if (!found) begin bad++; $display("FAIL split_wvalid_wait got=none want=WVALID"); end
    total++;
    if ({bus.AWVALID, bus.WVALID, bus.BREADY} !== 3'b110) begin
      bad++; $display("FAIL split_c1 got=%b want=110", {bus.AWVALID, bus.WVALID, bus.BREADY});
    end
    @(negedge CLK);
    total++;
    if ({bus.AWVALID, bus.WVALID, bus.BREADY} !== 3'b010) begin
      bad++; $display("FAIL split_c2 got=%b want=010", {bus.AWVALID, bus.WVALID, bus.BREADY});
    end
    @(negedge CLK);
    total++;
    if ({bus.AWVALID, bus.WVALID, bus.BREADY} !== 3'b010) begin
      bad++; $display("FAIL split_c3 got=%b want=010", {bus.AWVALID, bus.WVALID, bus.BREADY});
    end
    @(negedge CLK);
    total++;
    if ({bus.AWVALID, bus.WVALID, bus.BREADY} !== 3'b001) begin
      bad++; $display("FAIL split_c4 got=%b want=001", {bus.AWVALID, bus.WVALID, bus.BREADY});
    end
    wait_ack(20, n, expired);
    e = sb.pop_front();
    total++;
    if (expired || OUT_ACK !== 1'b1) begin bad++; $display("FAIL split_ack got=%b want=1", OUT_ACK); end
    total++;
    if (wr_log.size() != 1 || wr_log[0].data !== {24'h0, e.data} || wr_log[0].addr !== 4'h4) begin
      bad++; $display("FAIL split_write got=n%0d want=one write of %h", wr_log.size(), e.data);
    end
    w_delay = 0;
    @(negedge CLK);
  endtask

  task automatic test_err();
    int n; bit expired; exp_t e;
    stat_q = {8'h01}; rx_byte = 8'hA5; rx_resp = 2'b10;
    sb.push_back('{1'b0, 8'hA5});
    IN_REQ = 1'b1;
    wait_ack(50, n, expired);
    IN_REQ = 1'b0;
    e = sb.pop_front();
    total++;
    if (expired || IN_ACK !== 1'b1) begin bad++; $display("FAIL err_ack got=%b want=1", IN_ACK); end
    total++;
    if (IN_DATA !== e.data) begin bad++; $display("FAIL err_data got=%h want=%h", IN_DATA, e.data); end
    total++;
    if (ERR !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", ERR); end
    @(negedge CLK);
    rx_resp = 2'b00; stat_q = {8'h01}; rx_byte = 8'h3C;
    sb.push_back('{1'b0, 8'h3C});
    IN_REQ = 1'b1;
    wait_ack(50, n, expired);
    IN_REQ = 1'b0;
    e = sb.pop_front();
    total++;
    if (expired || IN_DATA !== e.data) begin bad++; $display("FAIL err_next_data got=%h want=%h", IN_DATA, e.data); end
    total++;
    if (ERR !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", ERR); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if (ERR !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", ERR); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int base; bit found;
    stat_q = {8'h01}; r_hold = 1'b1;
    base = in_ack_cnt;
    IN_REQ = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.RREADY === 1'b1) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_rready_wait got=none want=RREADY"); end
    RST = 1'b1; IN_REQ = 1'b0;
    @(negedge CLK);
    total++;
    if ({bus.ARVALID, bus.RREADY} !== 2'b00) begin
      bad++; $display("FAIL rstmid_drop got=%b want=00", {bus.ARVALID, bus.RREADY});
    end
    @(negedge CLK);
    r_hold = 1'b0;
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    total++;
    if (in_ack_cnt != base) begin bad++; $display("FAIL rstmid_no_ack got=%0d want=0", in_ack_cnt - base); end
  endtask

`ifdef UART_IO_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit expired; exp_t e;
    stat_q = {8'h01}; rx_byte = 8'h77;
    sb.push_back('{1'b0, 8'h77});
    IN_REQ = 1'b1;
    wait_ack(50, n, expired);
    IN_REQ = 1'b0;
    e = sb.pop_front();
    total++;
    if (expired || IN_DATA !== e.data) begin bad++; $display("FAIL to_pre_data got=%h want=%h", IN_DATA, e.data); end
    @(negedge CLK);
    stat_q.delete(); stat_default = 8'h00;
    sb.push_back('{1'b0, 8'h00});
    IN_REQ = 1'b1;
    wait_ack(300, n, expired);
    IN_REQ = 1'b0;
    e = sb.pop_front();
    total++;
    if (expired || n < int'(TO) || n > int'(TO + GAP + 3)) begin
      bad++; $display("FAIL to_latency got=%0d want=%0d..%0d", n, TO, TO + GAP + 3);
    end
    total++;
    if (IN_ACK !== 1'b1) begin bad++; $display("FAIL to_ack got=%b want=1", IN_ACK); end
    total++;
    if (IN_DATA !== e.data) begin bad++; $display("FAIL to_data got=%h want=%h", IN_DATA, e.data); end
    total++;
    if (ERR !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", ERR); end
    stat_default = 8'h01;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge CLK);
    test_reset();
    test_in_basic();
    test_out_poll();
    test_back_to_back();
    test_split_handshake();
    test_err();
    test_reset_mid();
`ifdef UART_IO_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_io_arbiter.md
Name: uart_io_arbiter

Overview:
- Sequences the core's IN/OUT byte I/O over one AXI4-Lite master port to the UART-Lite peripheral.
- Register map: RX 0x0, TX 0x4, STAT 0x8 (bit0 RX valid, bit3 TX full).
- Arbitrates between the core's IN and OUT requests and polls STAT before each data access.
- Returns a one-cycle ACK to the core, which holds its pipeline stalled until then.

Parameters:
- POLL_GAP, 4, idle cycles between a failed status poll and the next poll (0 = back-to-back).
- TIMEOUT, 1024, max cycles per transaction before abort (used only with UART_IO_TIMEOUT_EN).

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- IN_REQ  in  1  core requests one RX byte
- IN_DATA  out  8  received byte; valid when IN_ACK=1, held until next IN grant
- IN_ACK  out  1  one-cycle pulse, IN complete
- OUT_REQ  in  1  core requests one TX byte
- OUT_DATA  in  8  byte to send; sampled at grant
- OUT_ACK  out  1  one-cycle pulse, OUT complete
- ERR  out  1  sticky: nonzero RRESP/BRESP seen, or timeout
- ARADDR  out  4  read address
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- RDATA  in  32  read data
- RRESP  in  2  read response
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready
- AWADDR  out  4  write address
- AWVALID  out  1  write address valid
- AWREADY  in  1  write address ready
- WDATA  out  32  write data
- WSTRB  out  4  write strobe
- WVALID  out  1  write data valid
- WREADY  in  1  write data ready
- BRESP  in  2  write response
- BVALID  in  1  write response valid
- BREADY  out  1  write response ready

Behaviour:
- Reset: state IDLE; all VALID/READY, ACKs, ERR = 0; ARADDR/AWADDR/WDATA/IN_DATA = 0; WSTRB = 0; last_grant = OUT (so the first tie grants IN).
- Reset mid-transaction drops all VALID/READY at the next edge. No ACK is issued; the slave is reset alongside.
- States: IDLE, POLL_AR, POLL_R, GAP, RX_AR, RX_R, TX_W, TX_B, DONE.
- IDLE:
  - Samples REQs. One REQ high: grant it. Both high: grant the opposite of last_grant, then update last_grant.
  - On OUT grant, latch OUT_DATA.
  - Go to POLL_AR.
- POLL_AR: ARADDR=0x8, ARVALID=1 until ARREADY; then POLL_R.
- POLL_R: RREADY=1 until RVALID.
  - IN: RDATA[0]=1 -> RX_AR, else GAP.
  - OUT: RDATA[3]=0 -> TX_W, else GAP.
- GAP: counts POLL_GAP cycles, then POLL_AR. With POLL_GAP=0, GAP lasts 0 cycles (POLL_R goes directly to POLL_AR).
- RX_AR / RX_R: ARADDR=0x0 read. On R handshake, IN_DATA <= RDATA[7:0]; then DONE.
- TX_W:
  - AWADDR=0x4, WDATA={24'b0,byte}, WSTRB=4'b0001.
  - AWVALID and WVALID both rise on entry; each falls independently on its own handshake.
  - Go to TX_B once both handshakes are done (either order, or same cycle).
- TX_B: BREADY=1 until BVALID; then DONE.
- DONE: pulse the granted ACK for 1 cycle; return to IDLE. A REQ still high re-arbitrates on the next cycle.
- All VALIDs stay stable until their handshake. Address/data do not change while VALID=1.
- REQ is sampled only in IDLE. A REQ dropped mid-transaction does not abort it; the ACK still pulses.
- Any RRESP or BRESP != 0 sets ERR (sticky until RST). The transaction still completes and ACKs.
- Minimum latency, slave always ready, no repoll: ACK asserted 5 cycles after the IDLE grant edge, for both IN and OUT.

Optional Feature:
- Macro: UART_IO_TIMEOUT_EN.
- Defined: a per-transaction cycle counter clears at grant.
  - If it reaches TIMEOUT while in GAP or POLL_AR (no handshake outstanding), go to DONE: ACK pulses, ERR=1, IN_DATA=0 (IN case).
  - An outstanding AXI handshake is always completed first.
- Undefined: no counter; polling continues indefinitely.

Test Plan:
- IN, STAT=0x01, RX=0x5A, slave always ready -> ARADDR 0x8 then 0x0; IN_ACK 5 cycles after grant; IN_DATA=0x5A; ERR=0.
- OUT 0x41, STAT=0x08 for 3 polls then 0x00, POLL_GAP=4 -> 4 STAT reads, 4-cycle gaps; one write AWADDR=0x4, WDATA=0x00000041, WSTRB=0001; OUT_ACK once.
- IN_REQ and OUT_REQ both held high, 4 transactions -> grants IN, OUT, IN, OUT; each ACK a single-cycle pulse.
- TX_W with AWREADY 2 cycles before WREADY -> AWVALID falls first, WVALID held; B phase entered only after both handshakes.
- RRESP=2'b10 on RX read -> IN_ACK still pulses, ERR=1 and stays 1 until RST.
- UART_IO_TIMEOUT_EN, TIMEOUT=64, STAT always 0x00 for IN -> IN_ACK within 64+POLL_GAP+3 cycles, IN_DATA=0x00, ERR=1. RST asserted mid POLL_R -> RREADY=0 next edge, no ACK.
